uart_rx_mmio: RTL and testbench
===============================

// Module: uart_rx_mmio
// PURPOSE
//   UART receive path with a memory-mapped read port. It is the counterpart to the
//   write-side UART transmit path on the same peripheral bus.
//   - Deserialises 8N1 frames from rx_pin.
//   - Buffers received bytes in a small FIFO.
//   - Exposes data and status registers to the core through read_valid/read_address/read_data.
// PARAMETERS
//   CLK_FREQUENCY  50          clock frequency in MHz
//   BAUD_RATE      115200      line rate in bit/s; DIV = CLK_FREQUENCY*1000000/BAUD_RATE clocks per bit (DIV>=4)
//   BASE_ADDRESS   32'h10000000 register base; RXDATA at +0, STATUS at +1
//   FIFO_DEPTH     8           RX FIFO entries, power of two, >=2
// PORTS
//   clk_in        in   1   single clock; all logic rising-edge
//   rst           in   1   synchronous, active-high reset
//   rx_pin        in   1   asynchronous serial input, idle high
//   read_valid    in   1   one-cycle read strobe
//   read_address  in   32  read address, full 32-bit compare
//   read_data     out  32  registered read result
//   rx_irq        out  1   high while FIFO non-empty
// BEHAVIOUR
//   Reset:
//   - read_data=0, rx_irq=0, FIFO empty, overrun=0, frame_err=0, FSM=IDLE.
//   - Synchroniser flops reset to 1.
//   Input sync:
//   - rx_pin passes through 2 flops before any use (2-cycle latency).
//   Receive FSM, one bit counter counting 0..DIV-1:
//   - IDLE: on synced line 1->0, go to START and clear the counter.
//   - START: at count DIV/2-1, sample the line. If 1 (glitch), go to IDLE. If 0, go to DATA with bit index 0 and counter cleared.
//   - DATA: sample every DIV clocks, LSB first, into a shift register. After bit 7, go to STOP.
//   - STOP: sample after DIV clocks.
//     - If 1: push the byte into the FIFO and go to IDLE.
//     - If 0: set frame_err, discard the byte, go to BREAK.
//   - BREAK: wait for the synced line to be 1, then go to IDLE. No start detection while in BREAK.
//   FIFO:
//   - Push when the FIFO is full: byte dropped, overrun set (sticky).
//   - Pop and push in the same cycle: both take effect. When full, the pop frees the slot, so the push is accepted and count is unchanged. When empty, the pushed byte is stored, count becomes 1, and read_data returns 0.
//   - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
//   Read port (read_data is registered, valid the cycle after read_valid):
//   - RXDATA (+0):
//     - If non-empty: read_data={24'b0,head} and the head is popped in the strobe cycle.
//     - If empty: read_data=0, no pop, no flag change.
//   - STATUS (+1): read_data={28'b0,frame_err,overrun,full,~empty}. Reading STATUS clears overrun and frame_err. If the set and clear coincide, the set wins.
//   - Any other address: read_data=0, no side effects.
//   - read_data holds its value when read_valid=0.
//   - rx_irq = ~empty, registered from FIFO state.
//   Reset mid-frame:
//   - FSM returns to IDLE. Any partial byte and all FIFO contents are lost.
//   - Next start detection requires a fresh 1->0 edge after reset.
// TESTING (CLK_FREQUENCY=50, BAUD_RATE=5000000 -> DIV=10, 20 ns clock)
//   1. Drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop), then read +0
//      -> rx_irq rises after the stop sample; read_data=32'h000000A5 next cycle; rx_irq falls.
//   2. 40 ns low pulse on rx_pin, then line stays high
//      -> FSM returns to IDLE from START; FIFO stays empty; STATUS=0.
//   3. Frame 0x3C with stop bit held 0 for 20 bits, then high
//      -> STATUS=32'h8; no push; after the line goes high, frame 0x11 is received correctly.
//   4. Send 9 bytes 0x01..0x09 without reading, then read STATUS
//      -> STATUS=32'h7; data reads return 0x01..0x08; a second STATUS read returns 0x0.
//   5. With FIFO full, issue an RXDATA read in the same cycle as the stop-bit push
//      -> no overrun; count stays 8; the new byte ends up last.
//   6. Assert rst mid-DATA, then read +0 and +1
//      -> both return 0; the next complete frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_mmio_if.sv
// Core-side read bus of the UART receiver: strobe, address, registered data and irq.
// The master is the core and the slave is the peripheral.
interface uart_rx_mmio_if;
  logic        read_valid;
  logic [31:0] read_address;
  logic [31:0] read_data;
  logic        rx_irq;

  modport master (output read_valid, read_address, input read_data, rx_irq);
  modport slave  (input read_valid, read_address, output read_data, rx_irq);
endinterface

// File: rtl/uart_rx_mmio.sv
// 8N1 UART receiver with RX FIFO and MMIO read port. read_data is valid 1 cycle after read_valid.
// There is no backpressure to the line: a byte that arrives while the FIFO is full is dropped and flagged.
module uart_rx_mmio #(
  parameter int          CLK_FREQUENCY = 50,
  parameter int          BAUD_RATE     = 115200,
  parameter logic [31:0] BASE_ADDRESS  = 32'h10000000,
  parameter int          FIFO_DEPTH    = 8
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          rx_pin,
  uart_rx_mmio_if.slave bus
);
  localparam int DIV  = CLK_FREQUENCY * 1000000 / BAUD_RATE;
  localparam int CNTW = $clog2(DIV) + 1;
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [CNTW-1:0] HALF_M1 = CNTW'(DIV / 2 - 1);
  localparam logic [CNTW-1:0] FULL_M1 = CNTW'(DIV - 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  // sync_q[1] is the synchronised line, sync_q[2] its previous value for edge detection
  logic [2:0] sync_q;
  logic       line_s;

  always_ff @(posedge clk_in) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[1:0], rx_pin};
  end

  assign line_s = sync_q[1];

  state_t          state_q;
  logic [CNTW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            push_q;
  logic            ferr_set_q;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sync_q[2] && !line_s) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end
        START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= line_s ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {line_s, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (line_s) begin
              push_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              ferr_set_q <= 1'b1;
              state_q    <= BREAK;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BREAK:   if (line_s) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, frame_err_q, rx_irq_q;
  logic [31:0]   read_data_q, read_data_d;
  logic          empty, full, rd_data_hit, rd_stat_hit, pop, push_ok;

  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == DEPTH_C);
    rd_data_hit = bus.read_valid && (bus.read_address == BASE_ADDRESS);
    rd_stat_hit = bus.read_valid && (bus.read_address == BASE_ADDRESS + 32'd1);
    pop         = rd_data_hit && !empty;
    // a pop in the same cycle frees the slot the push needs
    push_ok     = push_q && (!full || pop);

    count_d = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;

    read_data_d = read_data_q;
    if (bus.read_valid) begin
      read_data_d = '0;
      if (pop)              read_data_d = {24'b0, mem_q[rd_ptr_q]};
      else if (rd_stat_hit) read_data_d = {28'b0, frame_err_q, overrun_q, full, !empty};
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
      read_data_q <= '0;
      rx_irq_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      overrun_q   <= (push_q && !push_ok) || (overrun_q && !rd_stat_hit);
      frame_err_q <= ferr_set_q || (frame_err_q && !rd_stat_hit);
      read_data_q <= read_data_d;
      rx_irq_q    <= (count_d != '0);
    end
  end

  assign bus.read_data = read_data_q;
  assign bus.rx_irq    = rx_irq_q;
endmodule

// File: tb/tb_uart_rx_mmio.sv
// Random and directed UART frames and reads, checked by a queue-based register model.
// The expected read results go into a scoreboard, and a monitor compares them on each read response.
module tb_uart_rx_mmio;
  localparam int          DIV   = 10;
  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h10000000;

  logic clk_in = 1'b0;
  logic rst;
  logic rx_pin;

  uart_rx_mmio_if bus ();

  uart_rx_mmio #(
    .CLK_FREQUENCY(50),
    .BAUD_RATE    (5000000),
    .BASE_ADDRESS (BASE),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .rx_pin(rx_pin),
    .bus   (bus)
  );

  always #10 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  string       name_q [$];

  // register model: FIFO contents and sticky flags as seen by software
  logic [7:0] mdl_q [$];
  logic       mdl_ovr  = 1'b0;
  logic       mdl_ferr = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic rd(input logic [31:0] addr, input string nm);
    logic [31:0] e;
    e = '0;
    if (addr == BASE) begin
      if (mdl_q.size() > 0) e = {24'b0, mdl_q.pop_front()};
    end else if (addr == BASE + 32'd1) begin
      e = {28'b0, mdl_ferr, mdl_ovr, mdl_q.size() == DEPTH, mdl_q.size() != 0};
      mdl_ferr = 1'b0;
      mdl_ovr  = 1'b0;
    end
    exp_q.push_back(e);
    name_q.push_back(nm);
    bus.read_valid   = 1'b1;
    bus.read_address = addr;
    tick(1);
    bus.read_valid   = 1'b0;
    bus.read_address = '0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_bits);
    rx_pin = 1'b0;
    tick(DIV);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      tick(DIV);
    end
    rx_pin = stop_val;
    tick(DIV * stop_bits);
    rx_pin = 1'b1;
    if (stop_val) begin
      if (mdl_q.size() < DEPTH) mdl_q.push_back(b);
      else                      mdl_ovr = 1'b1;
    end else begin
      mdl_ferr = 1'b1;
    end
    tick(2);
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      if (bus.read_valid === 1'b1) begin
        @(negedge clk_in);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_read actual=%h expected=no_pending_read", bus.read_data);
        end else begin
          chk(name_q.pop_front(), bus.read_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (90000) @(posedge clk_in);
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    rx_pin           = 1'b1;
    bus.read_valid   = 1'b0;
    bus.read_address = '0;
    tick(5);
    chk("reset_read_data", bus.read_data, 32'h0);
    chk("reset_irq", {31'b0, bus.rx_irq}, 32'h0);
    rst = 1'b0;
    tick(3);

    send_frame(8'hA5, 1'b1, 1);
    chk("t1_irq_rise", {31'b0, bus.rx_irq}, {31'b0, mdl_q.size() != 0});
    rd(BASE, "t1_rxdata");
    chk("t1_irq_fall", {31'b0, bus.rx_irq}, {31'b0, mdl_q.size() != 0});

    rx_pin = 1'b0;
    tick(2);
    rx_pin = 1'b1;
    tick(3 * DIV);
    rd(BASE + 32'd1, "t2_status");
    rd(BASE, "t2_rxdata_empty");

    send_frame(8'h3C, 1'b0, 20);
    rd(BASE + 32'd1, "t3_status_ferr");
    send_frame(8'h11, 1'b1, 1);
    rd(BASE, "t3_rxdata_after_break");
    rd(BASE + 32'd1, "t3_status_clear");

    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1);
    rd(BASE + 32'd1, "t4_status_overrun");
    for (int i = 0; i < 8; i++) rd(BASE, "t4_rxdata");
    rd(BASE + 32'd1, "t4_status_clear");

    for (int i = 0; i < 8; i++) send_frame(8'h40 + 8'(i), 1'b1, 1);
    // the read strobe lands in the cycle the stop-bit push reaches the FIFO
    fork
      send_frame(8'hC7, 1'b1, 1);
      begin
        tick(98);
        rd(BASE, "t5_pop_with_push");
      end
    join
    rd(BASE + 32'd1, "t5_status_full");
    for (int i = 0; i < 8; i++) rd(BASE, "t5_drain");

    send_frame(8'h77, 1'b1, 1);
    rx_pin = 1'b0;
    tick(DIV);
    rx_pin = 1'b1;
    tick(DIV);
    rx_pin = 1'b0;
    tick(DIV / 2);
    rst    = 1'b1;
    rx_pin = 1'b1;
    tick(3);
    rst = 1'b0;
    mdl_q.delete();
    mdl_ovr  = 1'b0;
    mdl_ferr = 1'b0;
    tick(3);
    chk("t6_irq_after_reset", {31'b0, bus.rx_irq}, 32'h0);
    rd(BASE, "t6_rxdata_after_reset");
    rd(BASE + 32'd1, "t6_status_after_reset");
    send_frame(8'h5A, 1'b1, 1);
    rd(BASE, "t6_rxdata_5a");

    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 5)       send_frame(8'($urandom), 1'b1, 1);
      else if (r == 5) send_frame(8'($urandom), 1'b0, int'($urandom_range(1, 3)));
      else if (r < 8)  rd(BASE, "rnd_rxdata");
      else if (r == 8) rd(BASE + 32'd1, "rnd_status");
      else             rd(BASE + 32'($urandom_range(2, 1000)), "rnd_other");
    end
    rd(BASE + 32'd1, "final_status");
    for (int i = 0; i < DEPTH; i++) rd(BASE, "final_drain");
    chk("final_irq", {31'b0, bus.rx_irq}, {31'b0, mdl_q.size() != 0});

    tick(5);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
